// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with load-use stall, flush bubble and bubble counter
module id_ex_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 9,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic              id_alusrc,
  input  logic              id_memtoreg,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic [1:0]        id_aluop,
  input  logic              id_branch,
  input  logic [PC_W-1:0]   id_pc,
  input  logic [DATA_W-1:0] id_rd1,
  input  logic [DATA_W-1:0] id_rd2,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [2:0]        id_funct3,
  input  logic [6:0]        id_funct7,
  input  logic              ex_flush,
  output logic              ex_valid,
  output logic              ex_alusrc,
  output logic              ex_memtoreg,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic [1:0]        ex_aluop,
  output logic              ex_branch,
  output logic [PC_W-1:0]   ex_pc,
  output logic [DATA_W-1:0] ex_rd1,
  output logic [DATA_W-1:0] ex_rd2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_AW-1:0] ex_rs1,
  output logic [REG_AW-1:0] ex_rs2,
  output logic [REG_AW-1:0] ex_rd,
  output logic [2:0]        ex_funct3,
  output logic [6:0]        ex_funct7,
  output logic              hz_stall,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic lu;
  logic rs2_used;
  logic bubble;

  // rs2 is only a real source when the ALU takes it (R-type) or a store writes it to memory
  assign rs2_used = ~id_alusrc | id_memwrite;
  assign lu = ex_valid & ex_memread & (ex_rd != '0) & id_valid &
              ((ex_rd == id_rs1) | ((ex_rd == id_rs2) & rs2_used));
  // A taken branch kills the ID instruction anyway, so it overrides the stall
  assign hz_stall = lu & ~ex_flush;
  assign bubble   = ex_flush | hz_stall;

  // Pipeline register: bubble on flush or stall, otherwise capture ID as-is
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_valid    <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_aluop    <= '0;
      ex_branch   <= 1'b0;
      ex_pc       <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7   <= '0;
    end else if (bubble) begin
      ex_valid    <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_aluop    <= '0;
      ex_branch   <= 1'b0;
      ex_pc       <= '0;
      ex_rd1      <= '0;
      ex_rd2      <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7   <= '0;
    end else begin
      ex_valid    <= id_valid;
      ex_alusrc   <= id_alusrc;
      ex_memtoreg <= id_memtoreg;
      ex_regwrite <= id_regwrite;
      ex_memread  <= id_memread;
      ex_memwrite <= id_memwrite;
      ex_aluop    <= id_aluop;
      ex_branch   <= id_branch;
      ex_pc       <= id_pc;
      ex_rd1      <= id_rd1;
      ex_rd2      <= id_rd2;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_funct7   <= id_funct7;
    end
  end

  // Saturating count of inserted bubbles; holds at all-ones rather than wrapping
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (bubble && (bubble_cnt != '1)) begin
      bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// tb/tb_id_ex_pipe_reg.sv - directed scoreboard bench for id_ex_pipe_reg
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic        alusrc;
    logic        memtoreg;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic [1:0]  aluop;
    logic        branch;
    logic [8:0]  pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
  } stage_t;

  typedef struct packed {
    stage_t     ex;
    logic [3:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite;
  logic [1:0]  id_aluop;
  logic        id_branch;
  logic [8:0]  id_pc;
  logic [31:0] id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic        ex_flush;
  logic        ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite;
  logic [1:0]  ex_aluop;
  logic        ex_branch;
  logic [8:0]  ex_pc;
  logic [31:0] ex_rd1, ex_rd2, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic        hz_stall;
  logic [3:0]  bubble_cnt;

  stage_t ex_obs;
  exp_t   sb[$];
  stage_t model_ex;
  logic [3:0] model_cnt;
  int n_checks = 0;
  int n_pass   = 0;
  logic [8:0] pc_ctr = 9'd0;

  always #5 clk = ~clk;

  id_ex_pipe_reg #(.DATA_W(32), .PC_W(9), .REG_AW(5), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_alusrc(id_alusrc), .id_memtoreg(id_memtoreg),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_aluop(id_aluop), .id_branch(id_branch), .id_pc(id_pc),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .ex_flush(ex_flush),
    .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_memtoreg(ex_memtoreg),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_aluop(ex_aluop), .ex_branch(ex_branch), .ex_pc(ex_pc),
    .ex_rd1(ex_rd1), .ex_rd2(ex_rd2), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .hz_stall(hz_stall), .bubble_cnt(bubble_cnt)
  );

  assign ex_obs = {ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite,
                   ex_aluop, ex_branch, ex_pc, ex_rd1, ex_rd2, ex_imm,
                   ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7};

  task automatic drive(input stage_t s, input logic flush);
    {id_valid, id_alusrc, id_memtoreg, id_regwrite, id_memread, id_memwrite,
     id_aluop, id_branch, id_pc, id_rd1, id_rd2, id_imm,
     id_rs1, id_rs2, id_rd, id_funct3, id_funct7} = s;
    ex_flush = flush;
  endtask

  task automatic chk_stall(input string tag, input logic want);
    n_checks++;
    assert (hz_stall === want) n_pass++;
    else $error("FAIL %s hz_stall got %b want %b", tag, hz_stall, want);
  endtask

  task automatic chk_ex(input string tag, input stage_t want);
    n_checks++;
    assert (ex_obs === want) n_pass++;
    else $error("FAIL %s ex got %h want %h", tag, ex_obs, want);
  endtask

  task automatic chk_cnt(input string tag, input logic [3:0] want);
    n_checks++;
    assert (bubble_cnt === want) n_pass++;
    else $error("FAIL %s bubble_cnt got %0d want %0d", tag, bubble_cnt, want);
  endtask

  function automatic stage_t rand_stage();
    stage_t s;
    s = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return s;
  endfunction

  function automatic stage_t mk(input logic valid, input logic alusrc, input logic memread,
                                input logic memwrite, input logic [1:0] aluop,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] rd1, input logic [31:0] rd2);
    stage_t s;
    s = rand_stage();
    s.valid    = valid;
    s.alusrc   = alusrc;
    s.memtoreg = memread;
    s.regwrite = ~memwrite;
    s.memread  = memread;
    s.memwrite = memwrite;
    s.aluop    = aluop;
    s.branch   = 1'b0;
    s.rs1      = rs1;
    s.rs2      = rs2;
    s.rd       = rd;
    s.rd1      = rd1;
    s.rd2      = rd2;
    return s;
  endfunction

  // One cycle: drive at negedge, check comb stall, push expected, compare after posedge
  task automatic step(input string tag, input stage_t s, input logic flush, input logic want_stall);
    exp_t e;
    exp_t got;
    @(negedge clk);
    s.pc = pc_ctr;
    pc_ctr = pc_ctr + 9'd1;
    drive(s, flush);
    #1;
    chk_stall(tag, want_stall);
    if (flush || want_stall) begin
      model_ex = '0;
      if (model_cnt != 4'hF) model_cnt = model_cnt + 4'd1;
    end else begin
      model_ex = s;
    end
    e.ex  = model_ex;
    e.cnt = model_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      $error("FAIL %s scoreboard empty got 0 want 1", tag);
    end else begin
      got = sb.pop_front();
      chk_ex(tag, got.ex);
      chk_cnt(tag, got.cnt);
    end
  endtask

  stage_t ld, use_i;

  initial begin
    model_ex  = '0;
    model_cnt = 4'd0;
    reset = 1'b0;
    drive(rand_stage(), 1'b1);
    #3;
    chk_ex("reset_async", '0);
    chk_cnt("reset_async", 4'd0);
    chk_stall("reset_async", 1'b0);
    @(posedge clk);
    #1;
    drive(rand_stage(), 1'b0);
    #1;
    chk_ex("reset_held", '0);
    chk_stall("reset_held", 1'b0);
    @(negedge clk);
    reset = 1'b1;

    step("pass_rtype", mk(1, 0, 0, 0, 2'b10, 5'd1, 5'd2, 5'd5, 32'h1234, 32'hABCD), 0, 0);
    ld = mk(1, 1, 1, 0, 2'b00, 5'd2, 5'd0, 5'd5, 32'h10, 32'h0);
    step("lw_x5", ld, 0, 0);
    use_i = mk(1, 0, 0, 0, 2'b10, 5'd5, 5'd3, 5'd6, 32'h55, 32'h66);
    step("loaduse_stall", use_i, 0, 1);
    step("loaduse_resume", use_i, 0, 0);

    step("lw_x0", mk(1, 1, 1, 0, 2'b00, 5'd1, 5'd0, 5'd0, 32'h1, 32'h2), 0, 0);
    step("rd0_nostall", mk(1, 1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd8, 32'h3, 32'h4), 0, 0);

    step("lw_x7", mk(1, 1, 1, 0, 2'b00, 5'd1, 5'd0, 5'd7, 32'h5, 32'h6), 0, 0);
    step("addi_rs2f", mk(1, 1, 0, 0, 2'b00, 5'd3, 5'd7, 5'd9, 32'h7, 32'h8), 0, 0);
    step("lw_x7b", mk(1, 1, 1, 0, 2'b00, 5'd1, 5'd0, 5'd7, 32'h9, 32'hA), 0, 0);
    use_i = mk(1, 1, 0, 1, 2'b00, 5'd3, 5'd7, 5'd0, 32'hB, 32'hC);
    step("sw_stall", use_i, 0, 1);
    step("sw_resume", use_i, 0, 0);

    step("idle", mk(0, 0, 1, 0, 2'b11, 5'd4, 5'd4, 5'd4, 32'hD, 32'hE), 0, 0);
    step("invalid_ex_load", mk(1, 0, 0, 0, 2'b10, 5'd4, 5'd4, 5'd1, 32'h1, 32'h1), 0, 0);

    step("lw_x9", mk(1, 1, 1, 0, 2'b00, 5'd1, 5'd0, 5'd9, 32'h0, 32'h0), 0, 0);
    step("flush_over_stall", mk(1, 0, 0, 0, 2'b10, 5'd9, 5'd1, 5'd2, 32'h1, 32'h2), 1, 0);

    step("chain_lw10", mk(1, 1, 1, 0, 2'b00, 5'd1, 5'd0, 5'd10, 32'h0, 32'h0), 0, 0);
    use_i = mk(1, 1, 1, 0, 2'b00, 5'd10, 5'd0, 5'd11, 32'h0, 32'h0);
    step("chain_stall1", use_i, 0, 1);
    step("chain_lw11", use_i, 0, 0);
    use_i = mk(1, 0, 0, 0, 2'b10, 5'd3, 5'd11, 5'd12, 32'h0, 32'h0);
    step("chain_stall2", use_i, 0, 1);
    step("chain_add", use_i, 0, 0);

    for (int i = 0; i < 20; i++) begin
      step("sat_flush", rand_stage(), 1, 0);
    end
    chk_cnt("saturated", 4'd15);

    step("lw_x5_again", mk(1, 1, 1, 0, 2'b00, 5'd2, 5'd0, 5'd5, 32'h0, 32'h0), 0, 0);
    @(negedge clk);
    drive(mk(1, 0, 0, 0, 2'b10, 5'd5, 5'd1, 5'd3, 32'h0, 32'h0), 1'b0);
    #1;
    chk_stall("pre_reset_stall", 1'b1);
    #1;
    reset = 1'b0;
    #1;
    n_checks++;
    assert (ex_valid === 1'b0) n_pass++;
    else $error("FAIL reset_midstall ex_valid got %b want 0", ex_valid);
    chk_stall("reset_midstall", 1'b0);
    chk_cnt("reset_midstall", 4'd0);
    chk_ex("reset_midstall", '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
